sram_model: RTL and testbench

SRAM_MODEL -- requirements
Module: sram_model

---
 rtl/sram_model.sv | 162 ++++++++++++++++
 tb/tb_sram_model.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_model.sv
// Cycle-based model of an asynchronous-style 16-bit SRAM, sampled on clk.
// Reads are served after a fixed latency; writes take effect in one cycle.
module sram_model #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] SRAM_DQ,
    input  logic [17:0] SRAM_ADDR,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    output logic        rd_valid,
    output logic [15:0] access_cnt,
    output logic        err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [17:0] addr_q, addr_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic [15:0] acc_q, acc_d;
    logic        err_q, err_d;

    logic        wr_req;
    logic        rd_req;
    logic        bump;
    logic        mem_we_hi;
    logic        mem_we_lo;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [15:0] rd_word;
    logic        drive;

    // Byte lanes are stored separately so a lane write never touches its neighbour.
    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    assign wr_req = ~SRAM_CE_N & ~SRAM_WE_N;
    assign rd_req = ~SRAM_CE_N & ~SRAM_OE_N;
    assign wr_idx = SRAM_ADDR[IDX_W-1:0];
    assign rd_idx = addr_q[IDX_W-1:0];

    // NOTE: every signal gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ub_n_d    = ub_n_q;
        lb_n_d    = lb_n_q;
        err_d     = err_q;
        acc_d     = acc_q;
        bump      = 1'b0;
        mem_we_hi = 1'b0;
        mem_we_lo = 1'b0;

        if (wr_req) begin
            // A write wins over any read in progress and aborts it.
            state_d   = IDLE;
            mem_we_hi = ~SRAM_UB_N & rst;
            mem_we_lo = ~SRAM_LB_N & rst;
            bump      = ~(SRAM_UB_N & SRAM_LB_N);
            if (!SRAM_OE_N) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        addr_d  = SRAM_ADDR;
                        ub_n_d  = SRAM_UB_N;
                        lb_n_d  = SRAM_LB_N;
                        cnt_d   = LAT_LOAD;
                        state_d = READ_WAIT;
                    end
                end
                READ_WAIT, READ_DRIVE: begin
                    if (!rd_req) begin
                        state_d = IDLE;
                    end else if (SRAM_ADDR != addr_q) begin
                        addr_d  = SRAM_ADDR;
                        ub_n_d  = SRAM_UB_N;
                        lb_n_d  = SRAM_LB_N;
                        cnt_d   = LAT_LOAD;
                        state_d = READ_WAIT;
                    end else if (state_q == READ_WAIT) begin
                        if (cnt_q == 4'd0) begin
                            state_d = READ_DRIVE;
                            bump    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else begin
                        ub_n_d = SRAM_UB_N;
                        lb_n_d = SRAM_LB_N;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (bump && (acc_q != 16'hFFFF)) begin
            acc_d = acc_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 18'd0;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            acc_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset; clearing it would cost a clear per word and the contents are defined as undefined.
    always_ff @(posedge clk) begin
        if (mem_we_hi) begin
            mem_hi[wr_idx] <= SRAM_DQ[15:8];
        end
        if (mem_we_lo) begin
            mem_lo[wr_idx] <= SRAM_DQ[7:0];
        end
    end

    // Drive enables come only from registered state, never straight from the pins.
    assign drive   = (state_q == READ_DRIVE);
    assign rd_word = {mem_hi[rd_idx], mem_lo[rd_idx]};

    assign SRAM_DQ[15:8] = (drive && !ub_n_q) ? rd_word[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive && !lb_n_q) ? rd_word[7:0]  : 8'hzz;

    assign rd_valid   = drive;
    assign access_cnt = acc_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sram_model.sv
// Self-checking bench for sram_model: a reference memory supplies expected
// read words, queued at request time and compared when rd_valid rises.
module tb_sram_model;

    localparam int DEPTH    = 1024;
    localparam int READ_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic        we_n, ce_n, oe_n, ub_n, lb_n;
    logic [15:0] tb_dq;
    logic        tb_dq_oe;
    wire  [15:0] sram_dq;
    logic        rd_valid;
    logic [15:0] access_cnt;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_cnt  = 0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_q [$];

    assign sram_dq = tb_dq_oe ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sram_model #(
        .DEPTH    (DEPTH),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (addr),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .rd_valid   (rd_valid),
        .access_cnt (access_cnt),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Released bits read as 0 whatever the simulator does with Z.
    function automatic logic [15:0] dq_now();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = (sram_dq[i] === 1'b1);
        return v;
    endfunction

    function automatic logic [15:0] expect_word(input logic [17:0] a, input logic ub, input logic lb);
        logic [15:0] w;
        w = model_mem[int'(a) % DEPTH];
        if (ub) w[15:8] = 8'h00;
        if (lb) w[7:0]  = 8'h00;
        return w;
    endfunction

    task automatic bus_idle();
        ce_n     = 1'b1;
        we_n     = 1'b1;
        oe_n     = 1'b1;
        ub_n     = 1'b0;
        lb_n     = 1'b0;
        tb_dq_oe = 1'b0;
        tb_dq    = 16'h0000;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input logic oe);
        int idx;
        idx      = int'(a) % DEPTH;
        addr     = a;
        tb_dq    = d;
        tb_dq_oe = 1'b1;
        ce_n     = 1'b0;
        we_n     = 1'b0;
        oe_n     = oe;
        ub_n     = ub;
        lb_n     = lb;
        tick();
        if (rst) begin
            if (!ub) model_mem[idx][15:8] = d[15:8];
            if (!lb) model_mem[idx][7:0]  = d[7:0];
            if (!(ub && lb)) exp_cnt++;
        end
        bus_idle();
    endtask

    task automatic start_read(input logic [17:0] a, input logic ub, input logic lb);
        addr = a;
        ce_n = 1'b0;
        we_n = 1'b1;
        oe_n = 1'b0;
        ub_n = ub;
        lb_n = lb;
        exp_q.push_back(expect_word(a, ub, lb));
    endtask

    // First edge is the request (or relatch) edge; data must follow READ_LAT edges later.
    task automatic await_valid(input string tag);
        int   edges;
        logic found;
        edges = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            edges++;
            if (rd_valid) found = 1'b1;
        end
        check({tag, " latency"}, edges - 1, READ_LAT);
        if (exp_q.size() > 0) begin
            logic [15:0] w;
            w = exp_q.pop_front();
            if (found) begin
                exp_cnt++;
                check({tag, " data"}, dq_now(), w);
            end
        end
    endtask

    task automatic end_read(input string tag);
        bus_idle();
        tick();
        check({tag, " release rd_valid"}, rd_valid, 1'b0);
        check({tag, " release dq"}, dq_now(), 16'h0000);
    endtask

    initial begin
        bus_idle();
        addr = 18'd0;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_valid", rd_valid, 1'b0);
        check("reset access_cnt", access_cnt, 16'd0);
        check("reset err", err, 1'b0);
        check("reset dq", dq_now(), 16'h0000);
        rst = 1'b1;
        tick();

        // Full-word write then read back.
        do_write(18'd5, 16'hA5C3, 1'b0, 1'b0, 1'b1);
        check("cnt after wr5", access_cnt, exp_cnt);
        start_read(18'd5, 1'b0, 1'b0);
        await_valid("rd5");
        check("rd5 literal", dq_now(), 16'hA5C3);
        check("cnt after rd5", access_cnt, 16'd2);
        tick();
        check("rd5 held valid", rd_valid, 1'b1);
        end_read("rd5");

        // Lane-masked writes and a masked read.
        do_write(18'd7, 16'h1234, 1'b0, 1'b0, 1'b1);
        do_write(18'd7, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        do_write(18'd7, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("cnt after lane writes", access_cnt, exp_cnt);
        start_read(18'd7, 1'b0, 1'b0);
        await_valid("rd7");
        check("rd7 literal", dq_now(), 16'h12FF);
        end_read("rd7");
        start_read(18'd7, 1'b0, 1'b1);
        await_valid("rd7 lb off");
        end_read("rd7 lb off");

        // Upper address bits are ignored.
        do_write(18'h00403, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        start_read(18'd3, 1'b0, 1'b0);
        await_valid("wrap");
        check("wrap literal", dq_now(), 16'hBEEF);
        end_read("wrap");

        // Address change while driving restarts the latency.
        do_write(18'd6, 16'h5A96, 1'b0, 1'b0, 1'b1);
        start_read(18'd5, 1'b0, 1'b0);
        await_valid("rd5 again");
        addr = 18'd6;
        exp_q.push_back(expect_word(18'd6, 1'b0, 1'b0));
        await_valid("relatch");
        ub_n = 1'b1;
        tick();
        check("be change valid", rd_valid, 1'b1);
        check("be change dq", dq_now(), {8'h00, model_mem[6][7:0]});
        check("cnt after relatch", access_cnt, exp_cnt);
        oe_n = 1'b1;
        tick();
        check("oe raise rd_valid", rd_valid, 1'b0);
        check("oe raise dq", dq_now(), 16'h0000);
        bus_idle();
        tick();

        // Write with OE asserted is contention: write happens, err sticks.
        do_write(18'd9, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        #1;
        check("contention err", err, 1'b1);
        check("contention rd_valid", rd_valid, 1'b0);
        check("contention dq", dq_now(), 16'h0000);
        repeat (3) tick();
        check("contention err sticky", err, 1'b1);
        start_read(18'd9, 1'b0, 1'b0);
        await_valid("rd9");
        check("rd9 literal", dq_now(), 16'h0F0F);
        end_read("rd9");
        check("cnt after rd9", access_cnt, exp_cnt);

        // Reset during READ_WAIT; writes under reset are dropped.
        addr = 18'd5;
        ce_n = 1'b0;
        we_n = 1'b1;
        oe_n = 1'b0;
        tick();
        #1 rst = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid-read reset dq", dq_now(), 16'h0000);
        check("mid-read reset cnt", access_cnt, 16'd0);
        check("mid-read reset rd_valid", rd_valid, 1'b0);
        check("mid-read reset err", err, 1'b0);
        do_write(18'd5, 16'h0000, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post reset no drive", {15'd0, rd_valid} | {16'd0} | dq_now(), 16'h0000);
        end
        start_read(18'd5, 1'b0, 1'b0);
        await_valid("rd5 post reset");
        check("cnt post reset", access_cnt, 16'd1);
        end_read("rd5 post reset");

        check("scoreboard empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
